fifo_rd_downsizer: RTL and testbench
====================================

# fifo_rd_downsizer

Read-side width converter for the asymmetric async FIFO: it takes wide words (e.g. 32-bit) from the FIFO read port and emits them as a stream of narrow slices (e.g. 8-bit). It is the wide-to-narrow counterpart of the FIFO's narrow-to-wide write/read path, and lives entirely in the read clock domain. Both sides use valid/ready handshakes, and throughput is one narrow slice per clock with no bubbles between words.

## Interface
- IN_WIDTH, 32, wide input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, narrow output slice width.
- RATIO, IN_WIDTH/OUT_WIDTH (4), slices per word; must be ≥2.
- CNT_WIDTH, 2, slice index width; must equal ceil(log2(RATIO)).
- LSB_FIRST, 1, 1: emit bits [OUT_WIDTH-1:0] first; 0: emit the MSB slice first.

Ports:
- rd_clk  input  1  single clock; all logic is rising-edge.
- rd_rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a wide word is available.
- in_ready  output  1  the block accepts a word this cycle (combinational from state and out_ready).
- in_data  input  IN_WIDTH  wide word.
- out_valid  output  1  a narrow slice is presented.
- out_ready  input  1  the sink accepts the slice.
- out_data  output  OUT_WIDTH  current slice.
- out_last  output  1  the current slice is the final slice of its word.
- slice_idx  output  CNT_WIDTH  index of the current slice within its word (0 = first emitted).

## Operation
- State: a word register, slice_idx, and the out_valid flag. There are two effective states:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1; a word is loaded and slice_idx selects the slice.
- in_ready = !out_valid || (out_ready && out_last).
- in_fire = in_valid && in_ready.
- out_fire = out_valid && out_ready.
- On in_fire: load in_data into the word register, set slice_idx=0, and set out_valid=1.
- On out_fire when out_last=0: increment slice_idx; the word register is unchanged.
- On out_fire when out_last=1 without in_fire: out_valid goes to 0 and slice_idx goes to 0.
- On out_fire when out_last=1 with in_fire (same cycle): load the new word and set slice_idx=0. out_valid stays 1 (back-to-back, no bubble).
- Slice selection:
  - LSB_FIRST=1: out_data = word[slice_idx*OUT_WIDTH +: OUT_WIDTH].
  - LSB_FIRST=0: out_data = word[(RATIO-1-slice_idx)*OUT_WIDTH +: OUT_WIDTH].
- out_last = out_valid && (slice_idx == RATIO-1).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and slice_idx hold stable, and in_ready=0.
- The block never drops or duplicates a slice. A word is accepted only when the previous word's last slice leaves, or when the block is empty.
- slice_idx wraps from RATIO-1 to 0 only through a reload or an empty transition. It never increments past RATIO-1.

## Timing
- Reset (asynchronous assert; release synchronous to rd_clk):
  - out_valid=0, slice_idx=0, word register=0, so out_data=0 and out_last=0.
  - in_ready=1 (EMPTY).
- Latency: a word accepted at edge N presents slice 0 at edge N, i.e. valid in cycle N+1.
- The last slice of a word is presented at cycle N+RATIO if out_ready is held high.
- Sustained throughput: one slice per cycle; one word per RATIO cycles.
- in_ready has a combinational path from out_ready. There is no combinational path from in_valid to out_*.
- Reset asserted mid-word: the in-flight word is discarded and the outputs return to their reset values immediately (asynchronously).
- in_valid may toggle freely while in_ready=0. in_data is sampled only on in_fire.

## Test plan
- Single word, LSB_FIRST=1:
  - Stimulus: in_data=0xDDCCBBAA with out_ready=1.
  - Required: out_data AA, BB, CC, DD on consecutive cycles, slice_idx 0..3, out_last only on DD, then out_valid=0.
- Single word, LSB_FIRST=0:
  - Stimulus: same word as above.
  - Required: DD, CC, BB, AA, with out_last on AA.
- Back-to-back words:
  - Stimulus: 0x44332211 then 0x88776655, with in_valid and out_ready held high.
  - Required: 8 slices 11..88 on 8 consecutive cycles with no out_valid gap; in_ready=1 exactly on the cycle out_last=1.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles while slice 0x22 is presented.
  - Required: out_data=0x22, slice_idx=1 and in_ready=0 held for all 3 cycles; the sequence resumes with 0x33 and no loss.
- Reset mid-word:
  - Stimulus: assert rd_rst_n=0 after slice BB.
  - Required: out_valid, out_data and out_last go to 0 at once and in_ready=1. After release, a new word 0x0F0E0D0C emits 0C, 0D, 0E, 0F.
- Idle gap:
  - Stimulus: in_valid low for 5 cycles after a word completes.
  - Required: out_valid=0 and in_ready=1 throughout the gap; the next word is accepted on its first valid cycle.

Source files
------------

// File: rtl/fifo_rd_downsizer_if.sv
// Handshake bundle between the FIFO read port (wide side) and the narrow slice sink.
// The slave modport is the downsizer's view; master is the surrounding environment's view.
interface fifo_rd_downsizer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [CNT_WIDTH-1:0] slice_idx;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output slice_idx
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  slice_idx
    );
endinterface

// File: rtl/fifo_rd_downsizer.sv
// Read-side width converter: splits each wide FIFO word into RATIO narrow slices,
// one slice per clock, reloading on the last slice so consecutive words stream without bubbles.
module fifo_rd_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
    parameter int CNT_WIDTH = 2,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    fifo_rd_downsizer_if.slave    bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  word_q, word_d;
    logic [CNT_WIDTH-1:0] slice_idx_q, slice_idx_d;

    logic                 out_valid;
    logic                 out_last;
    logic                 in_ready;
    logic                 in_fire;
    logic                 out_fire;
    logic [CNT_WIDTH-1:0] sel;
    logic [OUT_WIDTH-1:0] slices [RATIO];

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q     <= EMPTY;
            word_q      <= '0;
            slice_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            slice_idx_q <= slice_idx_d;
        end
    end

    // A new word may enter only when nothing is held or the held word's last slice leaves now.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        slice_idx_d = slice_idx_q;

        out_valid = (state_q == HOLD);
        out_last  = out_valid && (slice_idx_q == LAST_IDX);
        in_ready  = !out_valid || (bus.out_ready && out_last);
        in_fire   = bus.in_valid && in_ready;
        out_fire  = out_valid && bus.out_ready;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    word_d      = bus.in_data;
                    slice_idx_d = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    if (!out_last) begin
                        slice_idx_d = slice_idx_q + 1'b1;
                    end else if (in_fire) begin
                        word_d      = bus.in_data;
                        slice_idx_d = '0;
                    end else begin
                        slice_idx_d = '0;
                        state_d     = EMPTY;
                    end
                end
            end
            default: begin
                state_d     = EMPTY;
                slice_idx_d = '0;
            end
        endcase
    end

    // Emission order is fixed at elaboration; the slice index always counts 0..RATIO-1.
    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            slices[i] = word_q[i*OUT_WIDTH +: OUT_WIDTH];
        end
        if (LSB_FIRST) begin
            sel = slice_idx_q;
        end else begin
            sel = LAST_IDX - slice_idx_q;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.slice_idx = slice_idx_q;
    assign bus.out_data  = slices[sel];

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// Self-checking bench: LSB-first and MSB-first instances share one stimulus stream and are
// compared each cycle against a queue-of-slices reference model.
module tb_fifo_rd_downsizer;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int RATIO = 4;
    localparam int CNT_W = 2;

    logic             rd_clk;
    logic             rd_rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_ready;

    int tests_run;
    int tests_failed;

    logic [OUT_W-1:0] lsb_q [$];
    logic [OUT_W-1:0] msb_q [$];

    fifo_rd_downsizer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(CNT_W)) if_lsb ();
    fifo_rd_downsizer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(CNT_W)) if_msb ();

    assign if_lsb.in_valid  = in_valid;
    assign if_lsb.in_data   = in_data;
    assign if_lsb.out_ready = out_ready;
    assign if_msb.in_valid  = in_valid;
    assign if_msb.in_data   = in_data;
    assign if_msb.out_ready = out_ready;

    fifo_rd_downsizer #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .RATIO(RATIO), .CNT_WIDTH(CNT_W), .LSB_FIRST(1'b1)
    ) dut_lsb (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .bus      (if_lsb.slave)
    );

    fifo_rd_downsizer #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .RATIO(RATIO), .CNT_WIDTH(CNT_W), .LSB_FIRST(1'b0)
    ) dut_msb (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .bus      (if_msb.slave)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Each accepted word becomes RATIO pending slices, in emission order for each instance.
    task automatic pushWord(input logic [IN_W-1:0] w);
        for (int i = 0; i < RATIO; i++) lsb_q.push_back(w[i*OUT_W +: OUT_W]);
        for (int i = RATIO - 1; i >= 0; i--) msb_q.push_back(w[i*OUT_W +: OUT_W]);
    endtask

    task automatic checkAll();
        logic exp_valid;
        logic exp_ready;
        logic exp_last;
        int   exp_idx;
        exp_valid = (lsb_q.size() != 0);
        exp_last  = (lsb_q.size() == 1);
        exp_ready = !exp_valid || (out_ready && exp_last);
        exp_idx   = RATIO - lsb_q.size();
        checkOutput("lsb.out_valid", 32'(if_lsb.out_valid), 32'(exp_valid));
        checkOutput("msb.out_valid", 32'(if_msb.out_valid), 32'(exp_valid));
        checkOutput("lsb.in_ready", 32'(if_lsb.in_ready), 32'(exp_ready));
        checkOutput("msb.in_ready", 32'(if_msb.in_ready), 32'(exp_ready));
        if (exp_valid) begin
            checkOutput("lsb.out_data", 32'(if_lsb.out_data), 32'(lsb_q[0]));
            checkOutput("msb.out_data", 32'(if_msb.out_data), 32'(msb_q[0]));
            checkOutput("lsb.slice_idx", 32'(if_lsb.slice_idx), 32'(exp_idx));
            checkOutput("msb.slice_idx", 32'(if_msb.slice_idx), 32'(exp_idx));
            checkOutput("lsb.out_last", 32'(if_lsb.out_last), 32'(exp_last));
            checkOutput("msb.out_last", 32'(if_msb.out_last), 32'(exp_last));
        end else begin
            checkOutput("lsb.out_last", 32'(if_lsb.out_last), 32'd0);
            checkOutput("msb.out_last", 32'(if_msb.out_last), 32'd0);
        end
    endtask

    // Drive one cycle of inputs, check the presented state, then advance the model at the edge.
    task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d, input logic rdy);
        logic in_fire;
        logic out_fire;
        @(negedge rd_clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        checkAll();
        out_fire = (lsb_q.size() != 0) && rdy;
        in_fire  = v && ((lsb_q.size() == 0) || (rdy && lsb_q.size() == 1));
        @(posedge rd_clk);
        if (out_fire) begin
            void'(lsb_q.pop_front());
            void'(msb_q.pop_front());
        end
        if (in_fire) pushWord(d);
    endtask

    // Reset takes effect without a clock edge; outputs are checked while still asserted.
    task automatic resetAndCheck();
        #2;
        rd_rst_n = 1'b0;
        #1;
        checkOutput("rst.lsb.out_valid", 32'(if_lsb.out_valid), 32'd0);
        checkOutput("rst.msb.out_valid", 32'(if_msb.out_valid), 32'd0);
        checkOutput("rst.lsb.out_data", 32'(if_lsb.out_data), 32'd0);
        checkOutput("rst.msb.out_data", 32'(if_msb.out_data), 32'd0);
        checkOutput("rst.lsb.out_last", 32'(if_lsb.out_last), 32'd0);
        checkOutput("rst.msb.out_last", 32'(if_msb.out_last), 32'd0);
        checkOutput("rst.lsb.slice_idx", 32'(if_lsb.slice_idx), 32'd0);
        checkOutput("rst.lsb.in_ready", 32'(if_lsb.in_ready), 32'd1);
        checkOutput("rst.msb.in_ready", 32'(if_msb.in_ready), 32'd1);
        lsb_q.delete();
        msb_q.delete();
        repeat (2) @(negedge rd_clk);
        rd_rst_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rd_rst_n     = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;

        resetAndCheck();

        // Single word through both emission orders.
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1);

        // Back-to-back words with in_valid held high; second word taken on the last slice.
        applyStimulus(1'b1, 32'h44332211, 1'b1);
        repeat (4) applyStimulus(1'b1, 32'h88776655, 1'b1);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1);

        // Backpressure while slice 0x22 is presented, with in_valid toggling meanwhile.
        applyStimulus(1'b1, 32'h44332211, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h12345678, 1'b0);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

        // Idle gap then a word on the first valid cycle.
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset with slice CC pending, then a fresh word.
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        resetAndCheck();
        applyStimulus(1'b1, 32'h0F0E0D0C, 1'b1);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1);

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 7));
        end
        repeat (RATIO + 2) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
